// File: rtl/MuxParam_pkg.sv
// Shared types for the mux stage and its round-robin feeder.
// Holds op codes, the memory control word, arbiter state and the rr_next golden pick.
package MuxParam_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_AND   = 3'd5,
    OP_OR    = 3'd6,
    OP_XOR   = 3'd7
  } op_codes_e_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [1:0] size;
    logic       wr_en;
    logic       cacheable;
  } mem_ctl_st_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e_t;

  localparam int unsigned RR_MAX_N = 64;

  // Round-robin winner among n requesters starting at ptr; returns ptr when nothing requests.
  function automatic int unsigned rr_next(input int unsigned n, input int unsigned ptr,
                                          input logic [RR_MAX_N-1:0] req);
    int unsigned idx;
    rr_next = ptr;
    // Walk from the farthest slot back to ptr so the nearest active slot is written last.
    for (int k = RR_MAX_N - 1; k >= 0; k--) begin
      if (k < int'(n)) begin
        idx = (ptr + k) % n;
        if (req[idx]) rr_next = idx;
      end
    end
  endfunction

endpackage

// File: rtl/op_rr_arbiter_rr_pick.sv
// Combinational priority rotator: first active request at or after ptr, modulo 2**SEL.
module rr_pick import MuxParam_pkg::*; #(
  parameter int SEL = 2
) (
  input  logic [2**SEL-1:0] req,
  input  logic [SEL-1:0]    ptr,
  output logic [SEL-1:0]    winner,
  output logic              any
);

  localparam int N = 2**SEL;

  logic [SEL-1:0] idx;
  logic           found;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + k[SEL-1:0];
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/op_rr_arbiter.sv
// Round-robin arbiter feeding the mux stage, with a one-deep registered output and valid/ready.
// Optional OP_ARB_LOCK_EN adds a lock input that keeps priority on the granted source.
module op_rr_arbiter import MuxParam_pkg::*; #(
  parameter int SEL    = 2,
  parameter int RST_OP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2**SEL-1:0] req,
  input  op_codes_e_t       op_in  [2**SEL],
  input  mem_ctl_st_t       ctl_in [2**SEL],
  output logic [2**SEL-1:0] gnt,
  output logic [SEL-1:0]    sel,
  output logic              out_valid,
  input  logic              out_ready,
  output op_codes_e_t       out_op,
  output mem_ctl_st_t       out_ctl,
  output logic [SEL-1:0]    out_src
`ifdef OP_ARB_LOCK_EN
  ,
  input  logic              lock
`endif
);

  localparam logic [SEL-1:0] PTR_STEP = 1;

  arb_state_e_t   state_q, state_d;
  logic [SEL-1:0] ptr_q, ptr_d;
  logic [SEL-1:0] winner;
  logic           any;
  logic           can_load;
  logic           grant;
  logic           hold_ptr;

  rr_pick #(.SEL(SEL)) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

`ifdef OP_ARB_LOCK_EN
  assign hold_ptr = lock;
`else
  assign hold_ptr = 1'b0;
`endif

  assign can_load = (state_q == EMPTY) || out_ready;
  // Gated by rst_n so nothing is granted, or captured, while reset is held.
  assign grant    = rst_n && can_load && any;
  assign sel      = rst_n ? winner : '0;

  always_comb begin
    gnt = '0;
    if (grant) gnt[winner] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = hold_ptr ? winner : winner + PTR_STEP;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (out_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The held entry changes only on a capture, so it stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_op  <= op_codes_e_t'(RST_OP);
      out_ctl <= '0;
      out_src <= '0;
    end else if (grant) begin
      out_op  <= op_in[winner];
      out_ctl <= ctl_in[winner];
      out_src <= winner;
    end
  end

  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_op_rr_arbiter.sv
// Directed, table-driven bench for op_rr_arbiter (SEL=2) with hand-computed expectations.
// Includes lock sequences when built with OP_ARB_LOCK_EN.
module tb_op_rr_arbiter;
  import MuxParam_pkg::*;

  localparam int SEL = 2;
  localparam int N   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  op_codes_e_t       op_in  [N];
  mem_ctl_st_t       ctl_in [N];
  logic [N-1:0]      gnt;
  logic [SEL-1:0]    sel;
  logic              out_valid;
  logic              out_ready;
  op_codes_e_t       out_op;
  mem_ctl_st_t       out_ctl;
  logic [SEL-1:0]    out_src;
`ifdef OP_ARB_LOCK_EN
  logic              lock = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  op_rr_arbiter #(.SEL(SEL), .RST_OP(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_in     (op_in),
    .ctl_in    (ctl_in),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_ctl   (out_ctl),
    .out_src   (out_src)
`ifdef OP_ARB_LOCK_EN
    ,
    .lock      (lock)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] egnt;
    logic [1:0] esel;
    logic       evalid;
    logic [1:0] esrc;
  } vec_t;

  vec_t vecs [18];

  function automatic mem_ctl_st_t ctl_of(input int i);
    mem_ctl_st_t c;
    c.addr      = 8'h10 + 8'(i);
    c.size      = 2'(i);
    c.wr_en     = i[0];
    c.cacheable = ~i[0];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: check combinational grant/select, then the registered result after the edge.
  task automatic apply(input string tag, input logic [3:0] r, input logic rdy,
                       input logic [3:0] eg, input logic [1:0] es,
                       input logic ev, input logic [1:0] esrc);
    req       = r;
    out_ready = rdy;
    #1;
    check({tag, " gnt"}, 32'(gnt), 32'(eg));
    check({tag, " sel"}, 32'(sel), 32'(es));
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, " out_src"},   32'(out_src),   32'(esrc));
    check({tag, " out_op"},    32'(out_op),    32'(esrc));
    check({tag, " out_ctl"},   32'(out_ctl),   32'(ctl_of(int'(esrc))));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      op_in[i]  = op_codes_e_t'(i[2:0]);
      ctl_in[i] = ctl_of(i);
    end

    //            req      rdy   gnt      sel  valid src
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0};  // rotation starts at 0
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0};  // wrapped back to 0
    vecs[5]  = '{4'b0100, 1'b0, 4'b0000, 2'd2, 1'b1, 2'd0};  // backpressure x3
    vecs[6]  = '{4'b0100, 1'b0, 4'b0000, 2'd2, 1'b1, 2'd0};
    vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 2'd2, 1'b1, 2'd0};
    vecs[8]  = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};  // released, ptr->3
    vecs[9]  = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1};  // ptr 3 wraps to 1, ptr->2
    vecs[10] = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 2'd3};  // ptr 2 picks 3, ptr->0
    vecs[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd3};  // drain to EMPTY
    vecs[12] = '{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1};  // single pulse, ptr->2
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd1};  // valid exactly one cycle
    vecs[14] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 2'd1};
    vecs[15] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 2'd2};  // EMPTY loads without ready, ptr->3
    vecs[16] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};  // single requester every cycle
    vecs[17] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 2'd2};

    // Reset held with all requesting.
    rst_n     = 1'b0;
    req       = 4'b1111;
    out_ready = 1'b1;
    #12;
    check("rst gnt",       32'(gnt),       32'd0);
    check("rst sel",       32'(sel),       32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_ctl",   32'(out_ctl),   32'd0);
    check("rst out_op",    32'(out_op),    32'd0);
    check("rst out_src",   32'(out_src),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      apply($sformatf("v%0d", i), vecs[i].req, vecs[i].rdy, vecs[i].egnt,
            vecs[i].esel, vecs[i].evalid, vecs[i].esrc);

`ifdef OP_ARB_LOCK_EN
    // ptr is 3 here; lock pins priority on source 0.
    lock = 1'b1;
    apply("lock0", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0);
    apply("lock1", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0);
    lock = 1'b0;
    apply("lock2", 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0);
    apply("lock3", 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1);
`endif

    // Async reset mid-cycle while FULL and stalled.
    req       = 4'b1111;
    out_ready = 1'b0;
    #1;
    check("pre-rst out_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'd0);
    check("async gnt",       32'(gnt),       32'd0);
    check("async sel",       32'(sel),       32'd0);
    check("async out_src",   32'(out_src),   32'd0);
    check("async out_op",    32'(out_op),    32'd0);
    check("async out_ctl",   32'(out_ctl),   32'd0);
    @(posedge clk);
    #1;
    check("held rst out_valid", 32'(out_valid), 32'd0);
    check("held rst gnt",       32'(gnt),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post-rst0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 2'd0);
    apply("post-rst1", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
